// File: rtl/sobol_rng_nd_if.sv
// -----------------------------------------------------------------------------
// sobol_rng_nd_if
//   Bundles the control, direction-vector load and sample-stream signals of
//   sobol_rng_nd. clk and rst stay plain ports on the generator.
//
//   master : the controller / consumer side (drives en, restart, dv_*, out_ready)
//   slave  : the generator side (drives out_valid, sobol_seq, cnt, wrap)
//
//   en        run enable
//   restart   synchronous sequence restart (direction vectors kept)
//   dv_we     direction-vector write strobe
//   dv_dim    dimension being written
//   dv_idx    vector index being written (0 = MSB-weighted vector)
//   dv_data   vector value
//   out_valid sobol_seq holds a valid sample
//   out_ready consumer accepts the presented sample
//   sobol_seq NDIM packed samples, dim d at [d*WIDTH +: WIDTH]
//   cnt       index n of the presented sample
//   wrap      one-cycle pulse after the full 2^WIDTH period completes
// -----------------------------------------------------------------------------
interface sobol_rng_nd_if #(
    parameter int WIDTH = 16,
    parameter int NDIM  = 2
);
    localparam int DIMW = (NDIM > 1) ? $clog2(NDIM) : 1;
    localparam int IDXW = $clog2(WIDTH);

    logic                    en;
    logic                    restart;
    logic                    dv_we;
    logic [DIMW-1:0]         dv_dim;
    logic [IDXW-1:0]         dv_idx;
    logic [WIDTH-1:0]        dv_data;
    logic                    out_valid;
    logic                    out_ready;
    logic [NDIM*WIDTH-1:0]   sobol_seq;
    logic [WIDTH-1:0]        cnt;
    logic                    wrap;

    modport master (
        output en, restart, dv_we, dv_dim, dv_idx, dv_data, out_ready,
        input  out_valid, sobol_seq, cnt, wrap
    );

    modport slave (
        input  en, restart, dv_we, dv_dim, dv_idx, dv_data, out_ready,
        output out_valid, sobol_seq, cnt, wrap
    );
endinterface

// File: rtl/sobol_rng_nd.sv
// -----------------------------------------------------------------------------
// sobol_rng_nd
//   Multi-dimension Gray-code Sobol low-discrepancy generator. NDIM dimensions
//   share one WIDTH-bit step counter; each dimension owns a runtime-loadable
//   table of WIDTH direction vectors. Samples leave on a valid/ready stream.
//
//   clk  rising-edge clock
//   rst  synchronous, active-high reset (tables return to identity)
//   bus  sobol_rng_nd_if.slave: en, restart, dv_we/dv_dim/dv_idx/dv_data,
//        out_valid/out_ready, sobol_seq, cnt, wrap
// -----------------------------------------------------------------------------
module sobol_rng_nd #(
    parameter int WIDTH = 16,
    parameter int NDIM  = 2
) (
    input  logic           clk,
    input  logic           rst,
    sobol_rng_nd_if.slave  bus
);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] seq_q [NDIM];
    logic [WIDTH-1:0] seq_d [NDIM];
    logic [WIDTH-1:0] dv_q  [NDIM][WIDTH];
    logic [WIDTH-1:0] dv_d  [NDIM][WIDTH];
    logic             valid_q, valid_d;
    logic             wrap_q, wrap_d;

    logic             fire;
    logic             cnt_full;
    logic [WIDTH-1:0] step_bit;

    // valid_q is a register, so out_ready never reaches out_valid combinationally.
    assign fire     = valid_q & bus.out_ready;
    assign cnt_full = &cnt_q;
    // One-hot marker of the least-significant zero bit of cnt; all-zero when
    // cnt is all-ones (the wrap step).
    assign step_bit = ~cnt_q & (cnt_q + WIDTH'(1));

    always_comb begin
        // NOTE: every variable gets a default before any branch so no path
        // leaves it unassigned; otherwise synthesis infers a latch.
        cnt_d   = cnt_q;
        seq_d   = seq_q;
        dv_d    = dv_q;
        wrap_d  = 1'b0;
        valid_d = bus.en;

        if (bus.restart) begin
            cnt_d = '0;
            for (int d = 0; d < NDIM; d++) seq_d[d] = '0;
        end else if (fire) begin
            if (cnt_full) begin
                cnt_d  = '0;
                wrap_d = 1'b1;
                for (int d = 0; d < NDIM; d++) seq_d[d] = '0;
            end else begin
                cnt_d = cnt_q + WIDTH'(1);
                // Reads dv_q, so a same-cycle table write takes effect next step.
                for (int d = 0; d < NDIM; d++)
                    for (int k = 0; k < WIDTH; k++)
                        if (step_bit[k]) seq_d[d] = seq_q[d] ^ dv_q[d][k];
            end
        end

        // Exact-match decode: out-of-range dimension or index hits no entry.
        for (int d = 0; d < NDIM; d++)
            for (int k = 0; k < WIDTH; k++)
                if (bus.dv_we && int'(bus.dv_dim) == d && int'(bus.dv_idx) == k)
                    dv_d[d][k] = bus.dv_data;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            valid_q <= 1'b0;
            wrap_q  <= 1'b0;
            for (int d = 0; d < NDIM; d++) begin
                seq_q[d] <= '0;
                // NOTE: the direction tables are flops with reset, not RAM,
                // because reset must restore the identity table v[k] = 1<<(WIDTH-1-k).
                for (int k = 0; k < WIDTH; k++)
                    dv_q[d][k] <= WIDTH'(1) << (WIDTH - 1 - k);
            end
        end else begin
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            wrap_q  <= wrap_d;
            seq_q   <= seq_d;
            dv_q    <= dv_d;
        end
    end

    assign bus.out_valid = valid_q;
    assign bus.cnt       = cnt_q;
    assign bus.wrap      = wrap_q;

    for (genvar g = 0; g < NDIM; g++) begin : g_pack
        assign bus.sobol_seq[g*WIDTH +: WIDTH] = seq_q[g];
    end

endmodule

// File: tb/tb_sobol_rng_nd.sv
// -----------------------------------------------------------------------------
// tb_sobol_rng_nd
//   Self-checking bench for sobol_rng_nd (WIDTH=8, NDIM=3) plus a small
//   WIDTH=5, NDIM=1 instance used for out-of-range index writes and a closed-
//   form Gray-code check. A behavioural model steps each sample by the vector
//   selected from the single bit that changes between gray(n) and gray(n+1).
// -----------------------------------------------------------------------------
module tb_sobol_rng_nd;
    localparam int W  = 8;
    localparam int N  = 3;
    localparam int SW = 5;

    logic clk = 1'b0;
    logic rst;
    logic s_rst;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic chk_on = 1'b0;

    sobol_rng_nd_if #(.WIDTH(W), .NDIM(N)) bus ();
    sobol_rng_nd #(.WIDTH(W), .NDIM(N)) dut (.clk(clk), .rst(rst), .bus(bus));

    sobol_rng_nd_if #(.WIDTH(SW), .NDIM(1)) sbus ();
    sobol_rng_nd #(.WIDTH(SW), .NDIM(1)) u_small (.clk(clk), .rst(s_rst), .bus(sbus));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int gray(input int n);
        return n ^ (n >> 1);
    endfunction

    // Closed-form identity-table sample for the small instance: bit-reversed gray(n).
    function automatic logic [SW-1:0] ident5(input int n);
        int g;
        int r;
        g = gray(n);
        r = 0;
        for (int j = 0; j < SW; j++) if (g[j]) r = r | (1 << (SW - 1 - j));
        return SW'(r);
    endfunction

    // ---------------- behavioural model ----------------
    int           m_cnt;
    logic         m_valid;
    logic         m_wrap;
    logic [W-1:0] m_seq [N];
    logic [W-1:0] m_v   [N][W];

    always @(posedge clk) begin : model
        logic fire;
        int   diff;
        int   c;
        fire = m_valid && bus.out_ready;
        if (rst) begin
            m_cnt   = 0;
            m_valid = 1'b0;
            m_wrap  = 1'b0;
            for (int d = 0; d < N; d++) begin
                m_seq[d] = '0;
                for (int k = 0; k < W; k++) m_v[d][k] = W'(1) << (W - 1 - k);
            end
        end else begin
            m_wrap = 1'b0;
            if (bus.restart) begin
                m_cnt = 0;
                for (int d = 0; d < N; d++) m_seq[d] = '0;
            end else if (fire) begin
                if (m_cnt == (1 << W) - 1) begin
                    m_cnt  = 0;
                    m_wrap = 1'b1;
                    for (int d = 0; d < N; d++) m_seq[d] = '0;
                end else begin
                    diff = gray(m_cnt) ^ gray(m_cnt + 1);
                    c = 0;
                    for (int j = 0; j < W; j++) if ((diff >> j) == 1) c = j;
                    for (int d = 0; d < N; d++) m_seq[d] = m_seq[d] ^ m_v[d][c];
                    m_cnt++;
                end
            end
            // Table update after the step: the step above used the old vector.
            if (bus.dv_we && int'(bus.dv_dim) < N) m_v[bus.dv_dim][bus.dv_idx] = bus.dv_data;
            m_valid = bus.en;
        end
    end

    // ---------------- per-cycle comparison ----------------
    always @(negedge clk) begin
        if (chk_on) begin
            check("out_valid", 32'(bus.out_valid), 32'(m_valid));
            check("cnt", 32'(bus.cnt), 32'(m_cnt));
            check("wrap", 32'(bus.wrap), 32'(m_wrap));
            for (int d = 0; d < N; d++)
                check($sformatf("seq_dim%0d", d), 32'(bus.sobol_seq[d*W +: W]), 32'(m_seq[d]));
        end
    end

    // ---------------- stimulus ----------------
    logic [W-1:0] smp [N][8];
    logic [255:0] seen [N];
    logic [W-1:0] exp_id [8] = '{8'h00, 8'h80, 8'hC0, 8'h40, 8'h60, 8'hE0, 8'hA0, 8'h20};
    // dim1 with v0=0x80, v1=0xC0, v2=0xA0: n=3 -> gray 2 -> v1 alone = 0xC0.
    logic [W-1:0] exp_ld [5] = '{8'h00, 8'h80, 8'h40, 8'hC0, 8'h60};

    // Holds out_ready high and records the next `want` presented samples.
    task automatic collect(input int want);
        int n;
        int guard;
        n = 0;
        guard = 0;
        bus.out_ready = 1'b1;
        while (n < want && guard < 50) begin
            @(negedge clk);
            guard++;
            if (bus.out_valid) begin
                for (int d = 0; d < N; d++) smp[d][n] = bus.sobol_seq[d*W +: W];
                n++;
            end
        end
        check("collect_count", 32'(n), 32'(want));
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : stim
        int fires;
        int wraps;
        int guard;
        int n;
        logic [W-1:0] d_new;

        rst = 1'b1;          s_rst = 1'b1;
        bus.en = 1'b0;       bus.restart = 1'b0;  bus.dv_we = 1'b0;
        bus.dv_dim = '0;     bus.dv_idx = '0;     bus.dv_data = '0;
        bus.out_ready = 1'b0;
        sbus.en = 1'b0;      sbus.restart = 1'b0; sbus.dv_we = 1'b0;
        sbus.dv_dim = '0;    sbus.dv_idx = '0;    sbus.dv_data = '0;
        sbus.out_ready = 1'b0;

        repeat (2) @(posedge clk);
        chk_on = 1'b1;
        @(negedge clk);
        check("rst_cnt", 32'(bus.cnt), 32'(0));
        check("rst_valid", 32'(bus.out_valid), 32'(0));
        check("rst_seq", 32'(bus.sobol_seq), 32'(0));
        check("rst_wrap", 32'(bus.wrap), 32'(0));

        // Identity tables: first eight samples of dim0.
        rst = 1'b0;
        bus.en = 1'b1;
        collect(8);
        for (int i = 0; i < 8; i++) check($sformatf("t1_dim0_n%0d", i), 32'(smp[0][i]), 32'(exp_id[i]));

        // restart coincident with a fire: sample dropped, sequence back to 0.
        bus.restart = 1'b1;
        @(negedge clk);
        bus.restart = 1'b0;
        bus.out_ready = 1'b0;
        check("t6_restart_cnt", 32'(bus.cnt), 32'(0));
        check("t6_restart_seq", 32'(bus.sobol_seq), 32'(0));

        // Full period under random backpressure: each dim a permutation, one wrap.
        for (int d = 0; d < N; d++) seen[d] = '0;
        fires = 0;
        wraps = 0;
        guard = 0;
        while (fires < 256 && guard < 3000) begin
            guard++;
            bus.out_ready = ($urandom_range(3) != 0);
            if (bus.out_valid && bus.out_ready) begin
                for (int d = 0; d < N; d++) seen[d][bus.sobol_seq[d*W +: W]] = 1'b1;
                fires++;
            end
            @(negedge clk);
            if (bus.wrap) wraps++;
        end
        bus.out_ready = 1'b0;
        @(negedge clk);
        if (bus.wrap) wraps++;
        check("t2_fires", 32'(fires), 32'(256));
        check("t2_wraps", 32'(wraps), 32'(1));
        check("t2_cnt_zero", 32'(bus.cnt), 32'(0));
        check("t2_seq_zero", 32'(bus.sobol_seq), 32'(0));
        for (int d = 0; d < N; d++) check($sformatf("t2_perm_dim%0d", d), 32'(&seen[d]), 32'(1));

        // Five-cycle hold mid-stream.
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        bus.out_ready = 1'b0;
        repeat (5) @(negedge clk);
        check("t3_hold_cnt", 32'(bus.cnt), 32'(3));
        check("t3_hold_dim0", 32'(bus.sobol_seq[W-1:0]), 32'(8'h40));
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);

        // Load dim1 vectors 0..2 while idle.
        bus.en = 1'b0;
        bus.out_ready = 1'b0;
        bus.restart = 1'b1;
        @(negedge clk);
        bus.restart = 1'b0;
        bus.dv_we = 1'b1;
        bus.dv_dim = 2'd1;
        bus.dv_idx = 3'd0; bus.dv_data = 8'h80; @(negedge clk);
        bus.dv_idx = 3'd1; bus.dv_data = 8'hC0; @(negedge clk);
        bus.dv_idx = 3'd2; bus.dv_data = 8'hA0; @(negedge clk);
        bus.dv_we = 1'b0;
        bus.en = 1'b1;
        collect(5);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("t4_dim1_n%0d", i), 32'(smp[1][i]), 32'(exp_ld[i]));
            check($sformatf("t4_dim0_n%0d", i), 32'(smp[0][i]), 32'(exp_id[i]));
        end

        // cnt=4 presented and about to fire with index 0: rewrite dim0 v[0] now.
        d_new = 8'($urandom);
        bus.dv_we = 1'b1;
        bus.dv_dim = 2'd0;
        bus.dv_idx = 3'd0;
        bus.dv_data = d_new;
        @(negedge clk);
        bus.dv_we = 1'b0;
        check("t5_old_vec", 32'(bus.sobol_seq[W-1:0]), 32'(8'hE0));
        @(negedge clk);
        check("t5_mid", 32'(bus.sobol_seq[W-1:0]), 32'(8'hA0));
        @(negedge clk);
        check("t5_new_vec", 32'(bus.sobol_seq[W-1:0]), 32'(8'hA0 ^ d_new));

        // Out-of-range dimension write.
        bus.dv_we = 1'b1;
        bus.dv_dim = 2'd3;
        bus.dv_idx = 3'($urandom_range(7));
        bus.dv_data = 8'($urandom);
        @(negedge clk);
        bus.dv_we = 1'b0;
        repeat (6) @(negedge clk);

        // Reset mid-run restores identity tables in every dimension.
        rst = 1'b1;
        @(negedge clk);
        check("t6_rst_cnt", 32'(bus.cnt), 32'(0));
        check("t6_rst_valid", 32'(bus.out_valid), 32'(0));
        check("t6_rst_seq", 32'(bus.sobol_seq), 32'(0));
        rst = 1'b0;
        collect(8);
        for (int i = 0; i < 8; i++)
            for (int d = 0; d < N; d++)
                check($sformatf("t6_ident_dim%0d_n%0d", d, i), 32'(smp[d][i]), 32'(exp_id[i]));

        // Random traffic checked every cycle by the model.
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            bus.en        = ($urandom_range(15) != 0);
            bus.out_ready = ($urandom_range(1) != 0);
            bus.restart   = ($urandom_range(63) == 0);
            bus.dv_we     = ($urandom_range(15) == 0);
            bus.dv_dim    = 2'($urandom_range(3));
            bus.dv_idx    = 3'($urandom_range(7));
            bus.dv_data   = 8'($urandom);
        end
        @(negedge clk);
        bus.restart = 1'b0;
        bus.dv_we = 1'b0;
        bus.en = 1'b0;

        // Small instance: out-of-range index and dimension writes are ignored.
        s_rst = 1'b0;
        for (int k = 5; k < 8; k++) begin
            sbus.dv_we = 1'b1;
            sbus.dv_dim = 1'b0;
            sbus.dv_idx = 3'(k);
            sbus.dv_data = '1;
            @(negedge clk);
        end
        sbus.dv_dim = 1'b1;
        sbus.dv_idx = 3'd0;
        @(negedge clk);
        sbus.dv_we = 1'b0;
        sbus.en = 1'b1;
        sbus.out_ready = 1'b1;
        n = 0;
        guard = 0;
        while (n < 32 && guard < 100) begin
            @(negedge clk);
            guard++;
            if (sbus.out_valid) begin
                check($sformatf("small_seq_n%0d", n), 32'(sbus.sobol_seq), 32'(ident5(n)));
                check($sformatf("small_cnt_n%0d", n), 32'(sbus.cnt), 32'(n));
                n++;
            end
        end
        check("small_count", 32'(n), 32'(32));
        @(negedge clk);
        check("small_wrap", 32'(sbus.wrap), 32'(1));
        check("small_wrap_cnt", 32'(sbus.cnt), 32'(0));
        check("small_wrap_seq", 32'(sbus.sobol_seq), 32'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
